// File: rtl/commit_trace_unit.sv
// commit_trace_unit: logs retired register commits and stores from the MIPS core into a
// show-ahead trace FIFO for a valid/ready reader, and keeps pipeline event counters.
module commit_trace_unit #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Clear,
    input  logic             ID_PCWrite,
    input  logic             ID_BranchTaken,
    input  logic             ID_DoJump,
    input  logic             ID_DoJR,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_WriteRegister,
    input  logic [31:0]      WB_WriteData,
    input  logic [31:0]      WB_PCPlus8,
    input  logic             MEM_MemWrite,
    input  logic [31:0]      MEM_PCPlus8,
    output logic             Trace_Valid,
    input  logic             Trace_Ready,
    output logic [1:0]       Trace_Kind,
    output logic [4:0]       Trace_Reg,
    output logic [31:0]      Trace_PC,
    output logic [31:0]      Trace_Data,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] JumpCnt,
    output logic [CNT_W-1:0] CommitCnt,
    output logic [CNT_W-1:0] StoreCnt,
    output logic [CNT_W-1:0] DropCnt,
    output logic             Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 71;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          rst, valid, full, push_req, push, pop, drop;
    logic [EW-1:0] entry;

    assign rst      = Reset | Clear;
    assign valid    = count != '0;
    assign full     = count == (AW+1)'(DEPTH);
    assign push_req = Enable & (WB_RegWrite | MEM_MemWrite);
    assign pop      = valid & Trace_Ready;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts the push
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign entry    = WB_RegWrite ? {2'b01, WB_WriteRegister, WB_PCPlus8 - 32'd8, WB_WriteData}
                                  : {2'b10, 5'd0, MEM_PCPlus8 - 32'd8, 32'd0};

    assign Trace_Valid = valid;
    assign {Trace_Kind, Trace_Reg, Trace_PC, Trace_Data} = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge Clk) begin
        if (push && !rst)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            Overflow  <= 1'b0;
            CycleCnt  <= '0;
            StallCnt  <= '0;
            BranchCnt <= '0;
            JumpCnt   <= '0;
            CommitCnt <= '0;
            StoreCnt  <= '0;
            DropCnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCnt != '1)
                    DropCnt <= DropCnt + 1'b1;
            end
            if (Enable) begin
                CycleCnt <= CycleCnt + 1'b1;
                if (!ID_PCWrite)
                    StallCnt <= StallCnt + 1'b1;
                if (ID_BranchTaken)
                    BranchCnt <= BranchCnt + 1'b1;
                if (ID_DoJump || ID_DoJR)
                    JumpCnt <= JumpCnt + 1'b1;
                if (WB_RegWrite)
                    CommitCnt <= CommitCnt + 1'b1;
                if (MEM_MemWrite)
                    StoreCnt <= StoreCnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: directed stimulus with a scoreboard queue of expected trace entries
// checked by an independent monitor, plus direct checks of counters and flags.
module tb_commit_trace_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1, Enable = 1'b0, Clear = 1'b0;
    logic        ID_PCWrite = 1'b1, ID_BranchTaken = 1'b0, ID_DoJump = 1'b0, ID_DoJR = 1'b0;
    logic        WB_RegWrite = 1'b0, MEM_MemWrite = 1'b0, Trace_Ready = 1'b0;
    logic [4:0]  WB_WriteRegister = '0;
    logic [31:0] WB_WriteData = '0, WB_PCPlus8 = '0, MEM_PCPlus8 = '0;
    logic        Trace_Valid, Overflow;
    logic [1:0]  Trace_Kind;
    logic [4:0]  Trace_Reg;
    logic [31:0] Trace_PC, Trace_Data;
    logic [31:0] CycleCnt, StallCnt, BranchCnt, JumpCnt, CommitCnt, StoreCnt, DropCnt;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic [70:0] exp_q[$];

    commit_trace_unit #(.DEPTH(16), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear),
        .ID_PCWrite(ID_PCWrite), .ID_BranchTaken(ID_BranchTaken),
        .ID_DoJump(ID_DoJump), .ID_DoJR(ID_DoJR),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
        .WB_WriteData(WB_WriteData), .WB_PCPlus8(WB_PCPlus8),
        .MEM_MemWrite(MEM_MemWrite), .MEM_PCPlus8(MEM_PCPlus8),
        .Trace_Valid(Trace_Valid), .Trace_Ready(Trace_Ready),
        .Trace_Kind(Trace_Kind), .Trace_Reg(Trace_Reg), .Trace_PC(Trace_PC),
        .Trace_Data(Trace_Data),
        .CycleCnt(CycleCnt), .StallCnt(StallCnt), .BranchCnt(BranchCnt),
        .JumpCnt(JumpCnt), .CommitCnt(CommitCnt), .StoreCnt(StoreCnt),
        .DropCnt(DropCnt), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        cyc();
        Clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_commit(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p8);
        WB_RegWrite = 1'b1;
        WB_WriteRegister = r;
        WB_WriteData = d;
        WB_PCPlus8 = p8;
    endtask

    // scoreboard monitor: head must match the oldest expected entry while valid
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Trace_Valid) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_valid", 71'(Trace_Valid), 71'(0));
                    else begin
                        chk("trace_head", {Trace_Kind, Trace_Reg, Trace_PC, Trace_Data}, exp_q[0]);
                        if (Trace_Ready)
                            void'(exp_q.pop_front());
                    end
                end else
                    chk("empty_fields", {Trace_Kind, Trace_Reg, Trace_PC, Trace_Data}, 71'(0));
            end
        end
    end

    initial begin
        cyc(2);
        Reset = 1'b0;
        Enable = 1'b1;
        mon_en = 1'b1;
        cyc(10);
        chk("t1_cycle", 71'(CycleCnt), 71'(10));
        chk("t1_other", 71'({StallCnt, BranchCnt, JumpCnt} | {CommitCnt, StoreCnt, DropCnt}), 71'(0));
        chk("t1_valid", 71'(Trace_Valid), 71'(0));

        Trace_Ready = 1'b0;
        drive_commit(5'd5, 32'hFFFFFFFD, 32'd28);
        exp_q.push_back({2'b01, 5'd5, 32'd20, 32'hFFFFFFFD});
        cyc();
        WB_RegWrite = 1'b0;
        chk("t2_latency_valid", 71'(Trace_Valid), 71'(1));
        chk("t2_pc", 71'(Trace_PC), 71'(20));
        cyc(2);
        chk("t2_stable_data", 71'(Trace_Data), 71'(32'hFFFFFFFD));
        Trace_Ready = 1'b1;
        cyc();
        chk("t2_popped", 71'(Trace_Valid), 71'(0));
        drive_commit(5'd31, 32'h0, 32'd4);
        exp_q.push_back({2'b01, 5'd31, 32'hFFFFFFFC, 32'h0});
        cyc();
        WB_RegWrite = 1'b0;
        cyc(2);
        Trace_Ready = 1'b0;

        do_clear();
        drive_commit(5'd7, 32'h1234, 32'h108);
        MEM_MemWrite = 1'b1;
        MEM_PCPlus8 = 32'h200;
        exp_q.push_back({2'b01, 5'd7, 32'h100, 32'h1234});
        cyc();
        WB_RegWrite = 1'b0;
        chk("t3_commit", 71'(CommitCnt), 71'(1));
        chk("t3_store", 71'(StoreCnt), 71'(1));
        MEM_PCPlus8 = 32'h40;
        exp_q.push_back({2'b10, 5'd0, 32'h38, 32'h0});
        cyc();
        MEM_MemWrite = 1'b0;
        Trace_Ready = 1'b1;
        cyc(3);
        Trace_Ready = 1'b0;
        chk("t3_drained", 71'(exp_q.size()), 71'(0));

        do_clear();
        for (int i = 0; i < 20; i++) begin
            drive_commit(5'(i + 1), 32'h11 * i, 32'h1000 + 32'(4 * i));
            if (i < 16)
                exp_q.push_back({2'b01, 5'(i + 1), 32'h1000 + 32'(4 * i) - 32'd8, 32'h11 * i});
            cyc();
        end
        WB_RegWrite = 1'b0;
        chk("t4_drop", 71'(DropCnt), 71'(4));
        chk("t4_overflow", 71'(Overflow), 71'(1));
        chk("t4_commit", 71'(CommitCnt), 71'(20));

        Trace_Ready = 1'b1;
        drive_commit(5'd30, 32'hABCD, 32'h2000);
        exp_q.push_back({2'b01, 5'd30, 32'h1FF8, 32'hABCD});
        cyc();
        Trace_Ready = 1'b0;
        chk("t5_no_drop", 71'(DropCnt), 71'(4));
        drive_commit(5'd29, 32'h5555, 32'h3000);
        cyc();
        WB_RegWrite = 1'b0;
        chk("t5_still_full", 71'(DropCnt), 71'(5));
        Trace_Ready = 1'b1;
        cyc(20);
        Trace_Ready = 1'b0;
        chk("t5_drained", 71'(exp_q.size()), 71'(0));
        chk("t5_empty", 71'(Trace_Valid), 71'(0));

        do_clear();
        ID_PCWrite = 1'b0;
        cyc(3);
        ID_PCWrite = 1'b1;
        ID_DoJump = 1'b1;
        ID_DoJR = 1'b1;
        cyc();
        ID_DoJump = 1'b0;
        ID_DoJR = 1'b0;
        ID_BranchTaken = 1'b1;
        cyc(2);
        ID_BranchTaken = 1'b0;
        chk("t6_stall", 71'(StallCnt), 71'(3));
        chk("t6_jump", 71'(JumpCnt), 71'(1));
        chk("t6_branch", 71'(BranchCnt), 71'(2));
        chk("t6_cycle", 71'(CycleCnt), 71'(6));
        Enable = 1'b0;
        ID_PCWrite = 1'b0;
        drive_commit(5'd3, 32'h77, 32'h50);
        cyc();
        WB_RegWrite = 1'b0;
        ID_PCWrite = 1'b1;
        chk("t6_hold_stall", 71'(StallCnt), 71'(3));
        chk("t6_hold_cycle", 71'(CycleCnt), 71'(6));
        chk("t6_no_push", 71'(Trace_Valid), 71'(0));
        Enable = 1'b1;

        do_clear();
        for (int i = 0; i < 5; i++) begin
            drive_commit(5'(i + 10), 32'hA0 + 32'(i), 32'h400 + 32'(4 * i));
            exp_q.push_back({2'b01, 5'(i + 10), 32'h3F8 + 32'(4 * i), 32'hA0 + 32'(i)});
            cyc();
        end
        WB_RegWrite = 1'b0;
        chk("t7_queued", 71'(Trace_Valid), 71'(1));
        do_clear();
        chk("t7_valid", 71'(Trace_Valid), 71'(0));
        chk("t7_cycle", 71'(CycleCnt), 71'(0));
        chk("t7_commit", 71'(CommitCnt), 71'(0));
        chk("t7_overflow", 71'(Overflow), 71'(0));
        chk("t7_data", 71'(Trace_Data), 71'(0));
        cyc(2);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
